// File: rtl/sobel_stream_param.sv
// Streaming 3x3 Sobel edge stage: two line buffers build the window, then
// Gx/Gy, then |Gx|+|Gy| saturated or thresholded, with sop/eop framing.
module sobel_stream_param #(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic          din_sop,
  input  logic          din_eop,
  input  logic          mode,
  input  logic [DW-1:0] threshold,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic          frame_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DW + 3;

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic logic signed [GW-1:0] col_sum(input logic [DW-1:0] a,
                                                   input logic [DW-1:0] b,
                                                   input logic [DW-1:0] c);
    logic [GW-1:0] s;
    s = GW'(a) + (GW'(b) << 1) + GW'(c);
    return $signed(s);
  endfunction

  function automatic logic [GW-1:0] abs_val(input logic signed [GW-1:0] v);
    return v[GW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [DW-1:0] sat_mag(input logic [GW-1:0] m);
    return (|m[GW-1:DW]) ? {DW{1'b1}} : m[DW-1:0];
  endfunction

  state_t          state, state_nxt;
  logic [CW-1:0]   col, col_nxt, pc;
  logic [RW-1:0]   row, row_nxt, pr;
  logic            mode_q, mode_nxt;
  logic [DW-1:0]   thr_q, thr_nxt;
  logic            err_nxt, take, last, eop_bad, proc;

  logic [DW-1:0]   lb1 [IMG_W];
  logic [DW-1:0]   lb2 [IMG_W];

  logic [DW-1:0]   top_p0 [3];
  logic [DW-1:0]   mid_p0 [3];
  logic [DW-1:0]   bot_p0 [3];
  logic            mode_p0, mode_p1;
  logic [DW-1:0]   thr_p0, thr_p1;
  logic            vld_p0, sop_p0, eop_p0;

  logic signed [GW-1:0] gx_p1, gy_p1;
  logic            vld_p1, sop_p1, eop_p1;

  logic [DW-1:0]   sat_p1, pix_p1;
  logic            vld_p2, sop_p2, eop_p2;

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    mode_nxt  = mode_q;
    thr_nxt   = thr_q;
    err_nxt   = 1'b0;
    take      = din_vld && (state == ACTIVE || din_sop);
    pc        = din_sop ? '0 : col;
    pr        = din_sop ? '0 : row;
    last      = (pc == CW'(IMG_W - 1)) && (pr == RW'(IMG_H - 1));
    eop_bad   = din_eop && !last;
    proc      = take && !eop_bad;
    if (take) begin
      if (din_sop) begin
        mode_nxt = mode;
        thr_nxt  = threshold;
        if (state == ACTIVE) err_nxt = 1'b1;
      end
      if (eop_bad) begin
        // A premature eop drops the pixel and abandons the frame.
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end else if (last) begin
        state_nxt = IDLE;
        if (!din_eop) err_nxt = 1'b1;
      end else begin
        state_nxt = ACTIVE;
        if (pc == CW'(IMG_W - 1)) begin
          col_nxt = '0;
          row_nxt = pr + RW'(1);
        end else begin
          col_nxt = pc + CW'(1);
          row_nxt = pr;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      mode_q    <= 1'b0;
      thr_q     <= '0;
      frame_err <= 1'b0;
      vld_p0    <= 1'b0;
      sop_p0    <= 1'b0;
      eop_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      sop_p1    <= 1'b0;
      eop_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      sop_p2    <= 1'b0;
      eop_p2    <= 1'b0;
      dout      <= '0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      mode_q    <= mode_nxt;
      thr_q     <= thr_nxt;
      frame_err <= err_nxt;
      vld_p0    <= proc && (pr >= RW'(2)) && (pc >= CW'(2));
      sop_p0    <= proc && (pr == RW'(2)) && (pc == CW'(2));
      eop_p0    <= proc && last && din_eop;
      vld_p1    <= vld_p0;
      sop_p1    <= sop_p0;
      eop_p1    <= eop_p0;
      vld_p2    <= vld_p1;
      sop_p2    <= sop_p1;
      eop_p2    <= eop_p1;
      if (vld_p1) dout <= pix_p1;
    end
  end

  // Stage p0: line buffers shift rows down, window shifts one column left.
  always_ff @(posedge clk) begin
    if (proc) begin
      lb1[pc]   <= din;
      lb2[pc]   <= lb1[pc];
      top_p0[0] <= top_p0[1];
      top_p0[1] <= top_p0[2];
      top_p0[2] <= lb2[pc];
      mid_p0[0] <= mid_p0[1];
      mid_p0[1] <= mid_p0[2];
      mid_p0[2] <= lb1[pc];
      bot_p0[0] <= bot_p0[1];
      bot_p0[1] <= bot_p0[2];
      bot_p0[2] <= din;
      mode_p0   <= din_sop ? mode : mode_q;
      thr_p0    <= din_sop ? threshold : thr_q;
    end
  end

  // Stage p1: signed gradients, right minus left and bottom minus top.
  always_ff @(posedge clk) begin
    gx_p1   <= col_sum(top_p0[2], mid_p0[2], bot_p0[2])
             - col_sum(top_p0[0], mid_p0[0], bot_p0[0]);
    gy_p1   <= col_sum(bot_p0[0], bot_p0[1], bot_p0[2])
             - col_sum(top_p0[0], top_p0[1], top_p0[2]);
    mode_p1 <= mode_p0;
    thr_p1  <= thr_p0;
  end

  // Stage p2: magnitude, saturation and optional binarisation into dout.
  always_comb begin
    sat_p1 = sat_mag(abs_val(gx_p1) + abs_val(gy_p1));
    pix_p1 = mode_p1 ? sat_p1 : ((sat_p1 >= thr_p1) ? {DW{1'b1}} : '0);
  end

  assign dout_vld = vld_p2;
  assign dout_sop = sop_p2;
  assign dout_eop = eop_p2;

endmodule

// File: tb/tb_sobel_stream_param.sv
// Bench for sobel_stream_param on an 8x6 image: a direct Sobel model over the
// frame image predicts each output, its framing and its cycle.
module tb_sobel_stream_param;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din, threshold, dout;
  logic          din_vld, din_sop, din_eop, mode;
  logic          dout_vld, dout_sop, dout_eop, frame_err;

  always #5 clk = ~clk;

  sobel_stream_param #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sop(din_sop),
    .din_eop(din_eop), .mode(mode), .threshold(threshold), .dout(dout),
    .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .frame_err(frame_err)
  );

  typedef struct {
    int val;
    bit sop;
    bit eop;
    int due;
  } exp_t;

  exp_t q[$];
  int   img[W*H];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   outs  = 0;
  int   errs  = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic int pix(int r, int c);
    return img[r*W + c];
  endfunction

  // Raw |Gx|+|Gy| for the window completed by pixel (r,c), centre (r-1,c-1).
  function automatic int model_mag(int r, int c);
    int gx = 0, gy = 0, w;
    for (int d = -1; d <= 1; d++) begin
      w = (d == 0) ? 2 : 1;
      gx += w * (pix(r-1+d, c) - pix(r-1+d, c-2));
      gy += w * (pix(r, c-1+d) - pix(r-2, c-1+d));
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return gx + gy;
  endfunction

  function automatic int model_out(int r, int c, bit m, int t);
    int s;
    s = model_mag(r, c);
    if (s > 255) s = 255;
    if (m) return s;
    return (s >= t) ? 255 : 0;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      tests++;
      if (dout !== '0 || dout_vld !== 1'b0 || dout_sop !== 1'b0 ||
          dout_eop !== 1'b0 || frame_err !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: got dout=%0d vld=%b sop=%b eop=%b err=%b, want all 0",
                 dout, dout_vld, dout_sop, dout_eop, frame_err);
      end
    end else begin
      if (frame_err) errs++;
      if (dout_vld) begin
        tests++;
        outs++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_vld: got dout=%0d at cycle %0d, want no output", dout, cyc);
        end else begin
          e = q.pop_front();
          if (e.due != cyc) begin
            fails++;
            $display("FAIL vld_timing: got output at cycle %0d, want cycle %0d", cyc, e.due);
          end else if (dout != e.val || dout_sop != e.sop || dout_eop != e.eop) begin
            fails++;
            $display("FAIL dout: got val=%0d sop=%b eop=%b, want val=%0d sop=%b eop=%b",
                     dout, dout_sop, dout_eop, e.val, e.sop, e.eop);
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_output: got nothing at cycle %0d, want val=%0d due %0d",
                 cyc, q[0].val, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  task automatic idle_cycle();
    din_vld   = 1'b0;
    din       = DW'($urandom);
    din_sop   = 1'($urandom);
    din_eop   = 1'($urandom);
    mode      = 1'($urandom);
    threshold = DW'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) idle_cycle();
    din_sop = 1'b0;
    din_eop = 1'b0;
  endtask

  // Sends pixels 0..npix-1 of img; eop on the last one if with_eop.
  task automatic send_frame(input int npix, input bit with_eop, input int gap,
                            input bit m, input int t);
    exp_t e;
    int   r, c, guard;
    for (int k = 0; k < npix; k++) begin
      guard = 0;
      while (gap > 0 && $urandom_range(0, 99) < gap && guard < 8) begin
        idle_cycle();
        guard++;
      end
      din     = DW'(img[k]);
      din_vld = 1'b1;
      din_sop = (k == 0);
      din_eop = with_eop && (k == npix - 1);
      if (k == 0) begin
        mode      = m;
        threshold = DW'(t);
      end else begin
        mode      = 1'($urandom);
        threshold = DW'($urandom);
      end
      r = k / W;
      c = k % W;
      if (!(din_eop && k != W*H - 1) && r >= 2 && c >= 2) begin
        e.val = model_out(r, c, m, t);
        e.sop = (k == 2*W + 2);
        e.eop = din_eop && (k == W*H - 1);
        e.due = cyc + 3;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
  endtask

  task automatic fill_flat(input int v);
    for (int i = 0; i < W*H; i++) img[i] = v;
  endtask

  task automatic fill_step(input int lo, input int hi);
    for (int i = 0; i < W*H; i++) img[i] = ((i % W) >= 4) ? hi : lo;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < W*H; i++) img[i] = $urandom_range(0, 255);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int o0, e0, m, t, g;
    int edge_row[6];
    rst = 1'b1; din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    mode = 1'b0; threshold = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Model pins.
    fill_flat(100);
    chk("model_flat", model_mag(3, 4), 0);
    fill_step(0, 255);
    chk("model_edge_raw", model_mag(2, 5), 1020);
    edge_row = '{0, 0, 255, 255, 0, 0};
    for (int c = 2; c < 8; c++) chk("model_edge_row", model_out(2, c, 1'b1, 0), edge_row[c-2]);
    fill_step(0, 10);
    chk("model_step_mag", model_mag(3, 5), 40);
    chk("model_step_thr40", model_out(3, 4, 1'b0, 40), 255);
    chk("model_step_thr41", model_out(3, 4, 1'b0, 41), 0);

    // Valid pixels without sop are discarded while idle.
    o0 = outs;
    for (int k = 0; k < 30; k++) begin
      din = DW'($urandom); din_vld = 1'b1; din_sop = 1'b0; din_eop = 1'b0;
      @(posedge clk); #1;
    end
    din_vld = 1'b0;
    drain(5);
    chk("idle_discard", outs - o0, 0);

    fill_flat(100);
    o0 = outs; e0 = errs;
    send_frame(W*H, 1'b1, 0, 1'b1, 0);
    drain(6);
    chk("flat_count", outs - o0, 24);
    chk("flat_err", errs - e0, 0);

    fill_step(0, 255);
    o0 = outs;
    send_frame(W*H, 1'b1, 0, 1'b1, 0);
    drain(6);
    chk("edge_count", outs - o0, 24);

    fill_step(0, 10);
    o0 = outs;
    send_frame(W*H, 1'b1, 0, 1'b0, 40);
    drain(4);
    send_frame(W*H, 1'b1, 0, 1'b0, 41);
    drain(6);
    chk("step_count", outs - o0, 48);

    fill_step(0, 255);
    o0 = outs; e0 = errs;
    send_frame(W*H, 1'b1, 50, 1'b1, 0);
    drain(6);
    chk("gap_count", outs - o0, 24);
    chk("gap_err", errs - e0, 0);

    for (int i = 0; i < 3; i++) begin
      fill_rand();
      m = $urandom_range(0, 1);
      t = $urandom_range(0, 255);
      g = (i == 1) ? 0 : 50;
      o0 = outs;
      send_frame(W*H, 1'b1, g, 1'(m), t);
      drain(6);
      chk("rand_count", outs - o0, 24);
    end

    // Premature eop at pixel 20.
    fill_step(0, 255);
    o0 = outs; e0 = errs;
    send_frame(21, 1'b1, 0, 1'b1, 0);
    drain(6);
    chk("early_eop_err", errs - e0, 1);
    chk("early_eop_count", outs - o0, 2);
    fill_rand();
    o0 = outs; e0 = errs;
    send_frame(W*H, 1'b1, 0, 1'b0, 128);
    drain(6);
    chk("after_eop_count", outs - o0, 24);
    chk("after_eop_err", errs - e0, 0);

    // Second sop at pixel 30 restarts the frame.
    fill_step(0, 255);
    o0 = outs; e0 = errs;
    send_frame(30, 1'b0, 0, 1'b1, 0);
    fill_rand();
    send_frame(W*H, 1'b1, 0, 1'b1, 0);
    drain(6);
    chk("resop_err", errs - e0, 1);
    chk("resop_count", outs - o0, 34);

    // Reset in the middle of a frame.
    fill_rand();
    send_frame(25, 1'b0, 0, 1'b1, 0);
    rst = 1'b1;
    q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    fill_rand();
    o0 = outs; e0 = errs;
    send_frame(W*H, 1'b1, 0, 1'b1, 0);
    drain(6);
    chk("post_reset_count", outs - o0, 24);
    chk("post_reset_err", errs - e0, 0);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sobel_stream_param.md
Name: sobel_stream_param

Overview:
- Parametrised streaming 3x3 Sobel edge stage for the camera pipeline: gray/Gaussian stage -> this block -> VGA frame store.
- Accepts a vld/sop/eop pixel stream of DW-bit gray pixels.
- Builds a 3x3 window from two internal line buffers and computes |Gx|+|Gy|.
- Emits either saturated magnitude or a thresholded binary pixel, selectable per frame, with its own sop/eop framing and a frame-error flag.

Parameters:
- DW, 8, pixel width in bits (gray in, magnitude out).
- IMG_W, 640, pixels per line (>= 4).
- IMG_H, 480, lines per frame (>= 3).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- din  in  DW  input gray pixel.
- din_vld  in  1  din valid; gaps allowed, no back-pressure.
- din_sop  in  1  first pixel of frame, qualified by din_vld.
- din_eop  in  1  last pixel of frame, qualified by din_vld.
- mode  in  1  0 = binary output, 1 = magnitude output; sampled at sop.
- threshold  in  DW  binary threshold; sampled at sop.
- dout  out  DW  output pixel.
- dout_vld  out  1  dout valid.
- dout_sop  out  1  first output pixel of frame.
- dout_eop  out  1  last output pixel of frame.
- frame_err  out  1  one-cycle pulse on framing error.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters 0. Line-buffer contents are don't-care.
- Only cycles with din_vld=1 advance anything. sop/eop without vld are ignored.

FSM:
- IDLE: discard pixels until din_vld & din_sop.
  - That pixel is col 0, row 0.
  - Latch mode and threshold.
  - Go to ACTIVE.
- ACTIVE: col counts 0..IMG_W-1, wraps to 0 and increments row.
  - din_vld & din_eop at row=IMG_H-1, col=IMG_W-1: normal end, go to IDLE.
  - eop at any other position: frame_err pulse, go to IDLE, the current pixel is not processed.
  - sop while ACTIVE: frame_err pulse, then restart as a new frame using this pixel (col 0, row 0, re-latch mode and threshold).
  - Last pixel reached without eop: frame_err pulse, go to IDLE.

Window and output:
- Line buffers: two IMG_W x DW buffers hold rows r-1 and r-2, written at col on each valid pixel.
- Window: the 3x3 window is centred on (row-1, col-1).
- Windows produce output only when row >= 2 and col >= 2, i.e. interior centres only. Output frame is (IMG_W-2) x (IMG_H-2) pixels.
- Gx = (p[-1][+1] + 2p[0][+1] + p[+1][+1]) - (same taps in column -1). This is right minus left.
- Gy = bottom row minus top row, same weighting.
- Compute signed in DW+3 bits.
- mag = |Gx| + |Gy|, saturated to 2^DW-1.
- mode=1: dout = saturated mag.
- mode=0: dout = all-ones if mag >= threshold, else 0.

Timing:
- Latency: exactly 3 clk from the din_vld cycle completing a window to dout_vld. Stages: window register, Gx/Gy, abs/sum/saturate/threshold.
- Pipeline advances every clk; vld/sop/eop are delayed in parallel shift registers.
- dout_sop: first output window (row 2, col 2).
- dout_eop: window completed by input (IMG_H-1, IMG_W-1).

Error and reset cases:
- On any frame_err, in-flight pipeline outputs already launched still drain.
- No dout_eop is generated for an aborted frame.
- Reset mid-frame clears the pipeline immediately; no partial output follows.

Test Plan:
Bench uses IMG_W=8, IMG_H=6, DW=8.
- Flat frame, every pixel 100, mode=1 -> 24 outputs, all 0. sop on the 1st output, eop on the 24th; dout_vld 3 clk after input pixel (2,2).
- Vertical edge, cols 0-3 = 0 and cols 4-7 = 255, mode=1 -> each output row is 0,0,255,255,0,0 (raw 1020 saturated). 4 rows.
- Step 0 -> 10 at col 4, mode=0, threshold=40 -> centres col 3 and col 4 = 255, others 0. With threshold=41 all outputs are 0 (mag=40).
- Random din_vld gaps (50% duty) on the edge frame -> identical output values, sop/eop positions and count (24). The dout_vld pattern follows input gaps at 3 clk delay.
- Framing errors:
  - eop at pixel 20 -> frame_err pulse, no dout_eop, FSM IDLE, next sop accepted.
  - Second sop at pixel 30 -> frame_err, new frame's outputs correct.
- Reset asserted at pixel 25 -> all outputs 0 while rst=1. A fresh frame after release produces 24 correct outputs.
